aes_out_serializer: RTL and testbench

AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

---
 rtl/aes_out_serializer_if.sv | 11 +
 rtl/aes_out_serializer.sv | 105 ++++++++++
 tb/tb_aes_out_serializer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_out_serializer_if.sv
// Word-stream handshake carrying 32-bit ciphertext words out of aes_out_serializer.
// The master drives valid/data/last; the slave answers with ready.
interface aes_out_serializer_if;
    logic        ser_valid;
    logic        ser_ready;
    logic [31:0] ser_data;
    logic        ser_last;

    modport master (output ser_valid, output ser_data, output ser_last, input ser_ready);
    modport slave  (input ser_valid, input ser_data, input ser_last, output ser_ready);
endinterface

// File: rtl/aes_out_serializer.sv
// Buffers 128-bit AES ciphertext blocks in a 4-deep FIFO and streams each block
// out as four 32-bit words, most-significant word first.
module aes_out_serializer (
    input  logic                        AES_clk,
    input  logic                        AES_rst_n,
    input  logic                        AES_data_out_valid,
    input  logic [127:0]                AES_data_out,
    input  logic                        clr,
    aes_out_serializer_if.master        ser,
    output logic [2:0]                  fifo_cnt,
    output logic                        overflow
);
    localparam int unsigned DEPTH = 4;

    logic         valid_dly_q, valid_dly_d;
    logic [1:0]   wr_ptr_q, wr_ptr_d;
    logic [1:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]   w_q, w_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         overflow_q, overflow_d;
    logic [127:0] mem_q [DEPTH];

    logic         capture, xfer, pop, accept, wr_en;
    logic [127:0] head;

    // NOTE: every always_comb output gets a default first, otherwise an
    // unassigned branch infers a latch.
    always_comb begin
        capture     = AES_data_out_valid & ~valid_dly_q;
        xfer        = (cnt_q != 3'd0) & ser.ser_ready;
        pop         = xfer & (w_q == 2'd3);
        // A full FIFO still accepts when the head block leaves on this edge.
        accept      = capture & ((cnt_q != 3'd4) | pop);

        valid_dly_d = AES_data_out_valid;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        w_d         = w_q;
        cnt_d       = cnt_q;
        overflow_d  = overflow_q;
        wr_en       = 1'b0;

        if (clr) begin
            wr_ptr_d   = 2'd0;
            rd_ptr_d   = 2'd0;
            w_d        = 2'd0;
            cnt_d      = 3'd0;
            overflow_d = 1'b0;
        end else begin
            if (accept) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 2'd1;
            end else if (capture) begin
                overflow_d = 1'b1;
            end
            if (xfer) w_d = w_q + 2'd1;
            if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
            cnt_d = cnt_q + {2'b00, accept} - {2'b00, pop};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            valid_dly_q <= 1'b0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            w_q         <= 2'd0;
            cnt_q       <= 3'd0;
            overflow_q  <= 1'b0;
        end else begin
            valid_dly_q <= valid_dly_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            w_q         <= w_d;
            cnt_q       <= cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // NOTE: block storage has no reset; the count and pointers decide what is
    // valid, so stale contents are never observed.
    always_ff @(posedge AES_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= AES_data_out;
    end

    always_comb begin
        head = mem_q[rd_ptr_q];
        ser.ser_data = 32'd0;
        if (cnt_q != 3'd0) begin
            case (w_q)
                2'd0:    ser.ser_data = head[127:96];
                2'd1:    ser.ser_data = head[95:64];
                2'd2:    ser.ser_data = head[63:32];
                default: ser.ser_data = head[31:0];
            endcase
        end
    end

    assign ser.ser_valid = (cnt_q != 3'd0);
    assign ser.ser_last  = (cnt_q != 3'd0) & (w_q == 2'd3);
    assign fifo_cnt      = cnt_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed self-checking bench for aes_out_serializer: single block, held valid,
// backpressure, overflow, full-with-pop, clr and reset mid-stream.
module tb_aes_out_serializer;
    logic         clk;
    logic         rst_n;
    logic         aes_valid;
    logic [127:0] aes_data;
    logic         clr;
    logic [2:0]   fifo_cnt;
    logic         overflow;
    int           errors;
    int           checks;
    int           words;
    int           peak;

    aes_out_serializer_if sif ();

    aes_out_serializer dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_data_out_valid (aes_valid),
        .AES_data_out       (aes_data),
        .clr                (clr),
        .ser                (sif.master),
        .fifo_cnt           (fifo_cnt),
        .overflow           (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wrd(input int i, input int w);
        logic [7:0] a;
        logic [7:0] b;
        a = i[7:0];
        b = w[7:0];
        return {16'hB10C, a, b};
    endfunction

    function automatic logic [127:0] blk(input int i);
        return {wrd(i, 0), wrd(i, 1), wrd(i, 2), wrd(i, 3)};
    endfunction

    task automatic expect_word(input string tag, input logic [31:0] exp, input logic last);
        check({tag, "_valid"}, sif.ser_valid, 1'b1);
        check({tag, "_data"}, sif.ser_data, exp);
        check({tag, "_last"}, sif.ser_last, last);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, sif.ser_valid, 1'b0);
        check({tag, "_data"}, sif.ser_data, 32'd0);
        check({tag, "_last"}, sif.ser_last, 1'b0);
        check({tag, "_cnt"}, fifo_cnt, 3'd0);
        check({tag, "_ovf"}, overflow, 1'b0);
    endtask

    task automatic cap(input logic [127:0] d);
        aes_data  = d;
        aes_valid = 1'b1;
        tick();
        aes_valid = 1'b0;
        tick();
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        aes_valid     = 1'b0;
        aes_data      = '0;
        clr           = 1'b0;
        sif.ser_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();

        // Single block, ready held high, 1-cycle latency
        sif.ser_ready = 1'b1;
        aes_data      = 128'h00112233_44556677_8899aabb_ccddeeff;
        aes_valid     = 1'b1;
        tick();
        aes_valid = 1'b0;
        check("single_cnt1", fifo_cnt, 3'd1);
        expect_word("single_w0", 32'h00112233, 1'b0);
        tick();
        expect_word("single_w1", 32'h44556677, 1'b0);
        tick();
        expect_word("single_w2", 32'h8899aabb, 1'b0);
        tick();
        expect_word("single_w3", 32'hccddeeff, 1'b1);
        tick();
        check("single_empty_valid", sif.ser_valid, 1'b0);
        check("single_empty_cnt", fifo_cnt, 3'd0);

        // Held valid for 10 cycles gives exactly one block
        words     = 0;
        peak      = 0;
        aes_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c == 10) aes_valid = 1'b0;
            if (sif.ser_valid && sif.ser_ready) words++;
            tick();
            if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
        end
        check("held_words", words, 4);
        check("held_peak", peak, 1);

        // Backpressure: word 0 stable while ready is low
        sif.ser_ready = 1'b0;
        aes_data      = 128'h00112233_44556677_8899aabb_ccddeeff;
        aes_valid     = 1'b1;
        tick();
        aes_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            expect_word("bp_stall", 32'h00112233, 1'b0);
            tick();
        end
        sif.ser_ready = 1'b1;
        expect_word("bp_w0", 32'h00112233, 1'b0);
        tick();
        expect_word("bp_w1", 32'h44556677, 1'b0);
        tick();
        expect_word("bp_w2", 32'h8899aabb, 1'b0);
        tick();
        expect_word("bp_w3", 32'hccddeeff, 1'b1);
        tick();
        check("bp_empty", sif.ser_valid, 1'b0);

        // Overflow: five captures into a stalled FIFO, fifth dropped
        sif.ser_ready = 1'b0;
        for (int i = 0; i < 5; i++) cap(blk(i));
        check("ovf_cnt", fifo_cnt, 3'd4);
        check("ovf_flag", overflow, 1'b1);
        sif.ser_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 4; w++) begin
                expect_word("ovf_drain", wrd(i, w), (w == 3));
                tick();
            end
        end
        check("ovf_drained_valid", sif.ser_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // clr mid-stream with a 2-block backlog, clr beats a same-cycle capture
        sif.ser_ready = 1'b0;
        cap(blk(5));
        cap(blk(6));
        check("clr_backlog_cnt", fifo_cnt, 3'd2);
        sif.ser_ready = 1'b1;
        tick();
        expect_word("clr_pre_w1", wrd(5, 1), 1'b0);
        clr       = 1'b1;
        aes_valid = 1'b1;
        aes_data  = blk(9);
        tick();
        clr = 1'b0;
        check_idle("clr_after");
        tick();
        check("clr_no_recapture", fifo_cnt, 3'd0);
        aes_valid = 1'b0;
        tick();

        // Full FIFO with capture on the w=3 pop cycle
        sif.ser_ready = 1'b0;
        for (int i = 0; i < 4; i++) cap(blk(i));
        check("fullpop_pre_cnt", fifo_cnt, 3'd4);
        sif.ser_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            expect_word("fullpop_b0", wrd(0, w), 1'b0);
            tick();
        end
        expect_word("fullpop_b0_w3", wrd(0, 3), 1'b1);
        aes_valid = 1'b1;
        aes_data  = blk(4);
        tick();
        aes_valid = 1'b0;
        check("fullpop_cnt", fifo_cnt, 3'd4);
        check("fullpop_ovf", overflow, 1'b0);
        for (int i = 1; i < 5; i++) begin
            for (int w = 0; w < 4; w++) begin
                expect_word("fullpop_drain", wrd(i, w), (w == 3));
                tick();
            end
        end
        check("fullpop_empty", sif.ser_valid, 1'b0);

        // Reset mid-stream; valid already high at release captures once
        sif.ser_ready = 1'b0;
        cap(blk(5));
        cap(blk(6));
        sif.ser_ready = 1'b1;
        tick();
        expect_word("rst_pre_w1", wrd(5, 1), 1'b0);
        rst_n     = 1'b0;
        aes_valid = 1'b1;
        aes_data  = blk(7);
        #1;
        check_idle("rst_async");
        tick();
        check_idle("rst_held");
        rst_n         = 1'b1;
        sif.ser_ready = 1'b0;
        tick();
        check("rst_release_cnt", fifo_cnt, 3'd1);
        expect_word("rst_release_w0", wrd(7, 0), 1'b0);
        tick();
        tick();
        check("rst_single_capture", fifo_cnt, 3'd1);
        aes_valid     = 1'b0;
        sif.ser_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            expect_word("rst_drain", wrd(7, w), (w == 3));
            tick();
        end
        check("rst_end_valid", sif.ser_valid, 1'b0);
        check("rst_end_cnt", fifo_cnt, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
